// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to instruction memory,
// holds in-flight and returned words in a small in-order circular buffer, and
// hands completed instructions to the consumer. A redirect flushes the buffer
// and discards the responses to requests that are still in flight.
module instr_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic [XLEN-1:0]          instr_pc,
  output logic [XLEN-1:0]          instr_pc_plus4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q;
  logic [PW-1:0]   head_q;     // oldest allocated slot
  logic [PW-1:0]   tail_q;     // next slot to allocate
  logic [PW-1:0]   rsp_ptr_q;  // oldest slot still waiting for its word
  logic [PW:0]     count_q;    // allocated slots, pending + completed
  logic [PW:0]     out_q;      // requests in flight that will fill a slot
  logic [PW:0]     drop_q;     // requests in flight whose response is discarded

  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [31:0]     word_q [DEPTH];
  logic [DEPTH-1:0] done_q;

  logic        accept;
  logic        pop;
  logic        rsp_take;
  logic        rsp_any;
  logic [PW:0] inflight;

  // Request only when a slot is free, nothing is being dropped and no redirect
  // is replacing the fetch address this cycle.
  assign imem_req_valid = !reset && !redirect && (count_q < FULL) && (drop_q == '0);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign instr_valid    = done_q[head_q];
  assign instr          = word_q[head_q];
  assign instr_pc       = pc_q[head_q];
  assign instr_pc_plus4 = instr_pc + XLEN'(4);
  assign occupancy      = count_q;
  assign pop            = instr_valid && instr_ready;

  // Drop and fill phases never overlap: no request is issued while dropping,
  // and a redirect zeroes the fill count, so the sum is the true in-flight total.
  assign inflight = drop_q + out_q;
  assign rsp_any  = imem_rsp_valid && (inflight != '0);
  assign rsp_take = imem_rsp_valid && (drop_q == '0) && (out_q != '0);

  // Buffer, pointer, counter and fetch-address state.
  // NOTE: the slot storage is reset too, because instr and instr_pc must read
  // zero during reset and they come straight from the head slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      head_q     <= '0;
      tail_q     <= '0;
      rsp_ptr_q  <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      done_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else if (redirect) begin
      // Redirect overrides any pop, response or fill this cycle. A response
      // arriving now retires one of the in-flight requests.
      fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      head_q     <= '0;
      tail_q     <= '0;
      rsp_ptr_q  <= '0;
      count_q    <= '0;
      out_q      <= '0;
      done_q     <= '0;
      drop_q     <= inflight - (PW+1)'(rsp_any);
    end else begin
      // NOTE: non-blocking assignments throughout, so every update below reads
      // the pre-edge value of the pointers and counters it depends on.
      if (accept) begin
        pc_q[tail_q] <= fetch_pc_q;
        tail_q       <= tail_q + PW'(1);
        fetch_pc_q   <= fetch_pc_q + XLEN'(4);
      end
      if (rsp_take) begin
        word_q[rsp_ptr_q] <= imem_rsp_data;
        done_q[rsp_ptr_q] <= 1'b1;
        rsp_ptr_q         <= rsp_ptr_q + PW'(1);
      end
      if (pop) begin
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + PW'(1);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_q <= drop_q - (PW+1)'(1);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      case ({accept, rsp_take})
        2'b10:   out_q <= out_q + (PW+1)'(1);
        2'b01:   out_q <= out_q - (PW+1)'(1);
        default: out_q <= out_q;
      endcase
    end
  end

endmodule
